seq_mag_compare: RTL

- Parametrised, multi-cycle magnitude comparator.
- Compares two WIDTH-bit operands in CHUNK-bit slices, MSB slice first.
- Produces one-hot less/equal/greater flags with a start/busy/done handshake.
- Unsigned and two's-complement modes are selectable per operation.
- Serves datapaths where a full-width single-cycle compare does not meet timing or area.

---
 rtl/seq_mag_compare.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_mag_compare.sv
// -----------------------------------------------------------------------------
// seq_mag_compare
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared
// CHUNK bits at a time, most significant slice first, and the result is
// reported as one-hot lt/eq/gt flags together with a start/busy/done
// handshake. Each request selects unsigned or two's-complement ordering.
//
// Signed operation: the MSB of both operands is inverted on capture
// (offset-binary). That maps two's-complement ordering onto unsigned
// ordering, so the slice datapath is the same in both modes.
//
// Optional feature (compile-time macro):
//   SEQ_MAG_COMPARE_EARLY_EXIT_EN
//     defined   : RUN ends on the first unequal slice.
//                 The latency is the 1-based index of that slice, or
//                 NSLICE when the operands are equal.
//     undefined : RUN always lasts NSLICE cycles.
//                 The first unequal slice is held as a pending decision
//                 and is published on the final RUN edge.
//   Both builds produce the same result values.
//
// Parameters:
//   WIDTH        operand width in bits (integer multiple of CHUNK)
//   CHUNK        bits compared per cycle (1 <= CHUNK <= WIDTH)
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset (overrides start)
//   start        compare request, accepted only while busy = 0
//   signed_mode  1 = two's-complement, 0 = unsigned (sampled with start)
//   a, b         operands (sampled with start)
//   busy         high while a compare is running
//   done         one-cycle pulse when lt/eq/gt become valid
//   lt, eq, gt   result flags, one-hot after done, held until the next
//                accepted start or reset
// -----------------------------------------------------------------------------
module seq_mag_compare #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0]    ST_IDLE = 2'd0;
    localparam logic [1:0]    ST_RUN  = 2'd1;
    localparam logic [1:0]    ST_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LOAD = CW'(NSLICE - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Flip the sign bit so that two's-complement order equals unsigned order.
    function automatic logic [WIDTH-1:0] to_offset_binary(
        input logic [WIDTH-1:0] value,
        input logic             is_signed
    );
        logic [WIDTH-1:0] msb_mask;
        msb_mask            = {WIDTH{1'b0}};
        msb_mask[WIDTH-1]   = is_signed;
        return value ^ msb_mask;
    endfunction

    // Most significant CHUNK bits of a shift register.
    function automatic logic [CHUNK-1:0] top_slice(input logic [WIDTH-1:0] value);
        return value[WIDTH-1 -: CHUNK];
    endfunction

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
`ifndef SEQ_MAG_COMPARE_EARLY_EXIT_EN
    // The first unequal slice decides the result. The decision is held
    // here until the final RUN edge.
    logic             r_pend_vld;
    logic             r_pend_gt;
`endif

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_a_sh_nxt;
    logic [WIDTH-1:0] w_b_sh_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_lt_nxt;
    logic             w_eq_nxt;
    logic             w_gt_nxt;
`ifndef SEQ_MAG_COMPARE_EARLY_EXIT_EN
    logic             w_pend_vld_nxt;
    logic             w_pend_gt_nxt;
`endif

    logic             w_accept;
    logic [CHUNK-1:0] w_slice_a;
    logic [CHUNK-1:0] w_slice_b;
    logic             w_slice_gt;
    logic             w_slice_lt;
    logic             w_last;

    // Accept a request and compare the current top slices.
    always_comb begin
        w_accept   = start & ~r_busy;
        w_slice_a  = top_slice(r_a_sh);
        w_slice_b  = top_slice(r_b_sh);
        w_slice_gt = (w_slice_a > w_slice_b);
        w_slice_lt = (w_slice_a < w_slice_b);
        w_last     = (r_cnt == CNT_ZERO);
    end

    // Compute the next state of the FSM and the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_a_sh_nxt  = r_a_sh;
        w_b_sh_nxt  = r_b_sh;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_lt_nxt    = r_lt;
        w_eq_nxt    = r_eq;
        w_gt_nxt    = r_gt;
`ifndef SEQ_MAG_COMPARE_EARLY_EXIT_EN
        w_pend_vld_nxt = r_pend_vld;
        w_pend_gt_nxt  = r_pend_gt;
`endif

        case (r_state)
            // IDLE and DONE behave the same. Both accept a new request,
            // which makes back-to-back compares possible from DONE.
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                    w_a_sh_nxt  = to_offset_binary(a, signed_mode);
                    w_b_sh_nxt  = to_offset_binary(b, signed_mode);
                    w_cnt_nxt   = CNT_LOAD;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_lt_nxt    = 1'b0;
                    w_eq_nxt    = 1'b0;
                    w_gt_nxt    = 1'b0;
`ifndef SEQ_MAG_COMPARE_EARLY_EXIT_EN
                    w_pend_vld_nxt = 1'b0;
                    w_pend_gt_nxt  = 1'b0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end

            ST_RUN: begin
`ifdef SEQ_MAG_COMPARE_EARLY_EXIT_EN
                if (w_slice_gt || w_slice_lt) begin
                    w_state_nxt = ST_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_lt_nxt    = w_slice_lt;
                    w_eq_nxt    = 1'b0;
                    w_gt_nxt    = w_slice_gt;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_lt_nxt    = 1'b0;
                    w_eq_nxt    = 1'b1;
                    w_gt_nxt    = 1'b0;
                end else begin
                    w_a_sh_nxt  = r_a_sh << CHUNK;
                    w_b_sh_nxt  = r_b_sh << CHUNK;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
`else
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    // An earlier slice that already differed wins over
                    // the last slice.
                    if (r_pend_vld) begin
                        w_lt_nxt = ~r_pend_gt;
                        w_eq_nxt = 1'b0;
                        w_gt_nxt = r_pend_gt;
                    end else begin
                        w_lt_nxt = w_slice_lt;
                        w_eq_nxt = ~(w_slice_lt | w_slice_gt);
                        w_gt_nxt = w_slice_gt;
                    end
                end else begin
                    // Keep shifting after a decision so that RUN always
                    // takes NSLICE cycles. Later slices are ignored.
                    w_a_sh_nxt  = r_a_sh << CHUNK;
                    w_b_sh_nxt  = r_b_sh << CHUNK;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                    if (!r_pend_vld && (w_slice_gt || w_slice_lt)) begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_gt_nxt  = w_slice_gt;
                    end else begin
                        w_pend_vld_nxt = r_pend_vld;
                        w_pend_gt_nxt  = r_pend_gt;
                    end
                end
`endif
            end

            default: begin
                // An unreachable encoding recovers to a clean IDLE.
                w_state_nxt = ST_IDLE;
                w_a_sh_nxt  = {WIDTH{1'b0}};
                w_b_sh_nxt  = {WIDTH{1'b0}};
                w_cnt_nxt   = CNT_ZERO;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
                w_lt_nxt    = 1'b0;
                w_eq_nxt    = 1'b0;
                w_gt_nxt    = 1'b0;
`ifndef SEQ_MAG_COMPARE_EARLY_EXIT_EN
                w_pend_vld_nxt = 1'b0;
                w_pend_gt_nxt  = 1'b0;
`endif
            end
        endcase
    end

    // Register the state. Reset clears everything and discards any
    // compare that is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_sh  <= {WIDTH{1'b0}};
            r_b_sh  <= {WIDTH{1'b0}};
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
`ifndef SEQ_MAG_COMPARE_EARLY_EXIT_EN
            r_pend_vld <= 1'b0;
            r_pend_gt  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_a_sh  <= w_a_sh_nxt;
            r_b_sh  <= w_b_sh_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_lt    <= w_lt_nxt;
            r_eq    <= w_eq_nxt;
            r_gt    <= w_gt_nxt;
`ifndef SEQ_MAG_COMPARE_EARLY_EXIT_EN
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_gt  <= w_pend_gt_nxt;
`endif
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign lt   = r_lt;
    assign eq   = r_eq;
    assign gt   = r_gt;

endmodule
